// File: rtl/vending_controller.sv
// rtl/vending_controller.sv - coin-accepting product vendor with greedy coin-by-coin change return
// Credit accrues from one-hot coin strobes; change/refund is paid out over a valid/ack handshake.
module vending_controller #(
  parameter int CREDIT_WIDTH  = 8,
  parameter int PRODUCT_COUNT = 4,
  parameter logic [PRODUCT_COUNT*CREDIT_WIDTH-1:0] PRICE_LIST = {8'd30, 8'd25, 8'd20, 8'd15},
  parameter int MAX_CREDIT    = 35,
  parameter int NICKEL_VALUE  = 5,
  parameter int DIME_VALUE    = 10,
  parameter int QUARTER_VALUE = 25,
  localparam int IDX_W = (PRODUCT_COUNT > 1) ? $clog2(PRODUCT_COUNT) : 1
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic                     enable,
  input  logic [2:0]               coin,
  input  logic [PRODUCT_COUNT-1:0] select,
  input  logic                     cancel,
  input  logic                     change_ack,
  output logic [CREDIT_WIDTH-1:0]  credit,
  output logic [CREDIT_WIDTH-1:0]  price,
  output logic                     vend,
  output logic [IDX_W-1:0]         vend_index,
  output logic                     coin_reject,
  output logic                     short_credit,
  output logic                     change_valid,
  output logic [2:0]               change_coin,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    ST_ACCEPT  = 2'd0,
    ST_VEND    = 2'd1,
    ST_CHANGE  = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  localparam logic [CREDIT_WIDTH:0]   MAX_SUM  = (CREDIT_WIDTH+1)'(MAX_CREDIT);
  localparam logic [CREDIT_WIDTH-1:0] N_VAL    = CREDIT_WIDTH'(NICKEL_VALUE);
  localparam logic [CREDIT_WIDTH-1:0] D_VAL    = CREDIT_WIDTH'(DIME_VALUE);
  localparam logic [CREDIT_WIDTH-1:0] Q_VAL    = CREDIT_WIDTH'(QUARTER_VALUE);

  state_t                    r_state;
  logic [CREDIT_WIDTH-1:0]   r_credit;
  logic [CREDIT_WIDTH-1:0]   r_remaining;
  logic [IDX_W-1:0]          r_sel_idx;
  logic                      r_coin_reject;
  logic                      r_short_credit;

  state_t                    w_state_nxt;
  logic [CREDIT_WIDTH-1:0]   w_credit_nxt;
  logic [CREDIT_WIDTH-1:0]   w_remaining_nxt;
  logic [IDX_W-1:0]          w_sel_idx_nxt;
  logic                      w_coin_reject_nxt;
  logic                      w_short_credit_nxt;

  logic [CREDIT_WIDTH-1:0]   w_prices [PRODUCT_COUNT];
  logic                      w_coin_onehot;
  logic [CREDIT_WIDTH-1:0]   w_coin_value;
  logic [CREDIT_WIDTH:0]     w_coin_sum;
  logic                      w_sel_onehot;
  logic [IDX_W-1:0]          w_sel_idx;
  logic [CREDIT_WIDTH-1:0]   w_sel_price;
  logic [CREDIT_WIDTH-1:0]   w_vend_rem;
  logic [2:0]                w_change_coin;
  logic [CREDIT_WIDTH-1:0]   w_change_value;
  logic [CREDIT_WIDTH-1:0]   w_change_rem;

  for (genvar g = 0; g < PRODUCT_COUNT; g++) begin : g_price
    assign w_prices[g] = PRICE_LIST[g*CREDIT_WIDTH +: CREDIT_WIDTH];
  end

  assign w_coin_onehot = $onehot(coin);
  assign w_sel_onehot  = $onehot(select);

  always_comb begin
    w_coin_value = '0;
    case (coin)
      3'b001:  w_coin_value = N_VAL;
      3'b010:  w_coin_value = D_VAL;
      3'b100:  w_coin_value = Q_VAL;
      default: w_coin_value = '0;
    endcase
  end

  // One extra bit so a coin near the top of the credit range cannot wrap past the ceiling check.
  assign w_coin_sum = {1'b0, r_credit} + {1'b0, w_coin_value};

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < PRODUCT_COUNT; i++) begin
      if (select[i]) w_sel_idx = IDX_W'(i);
    end
  end

  assign w_sel_price = w_prices[w_sel_idx];
  assign w_vend_rem  = r_credit - w_prices[r_sel_idx];

  // Greedy payout: always offer the largest coin that still fits in what is owed.
  always_comb begin
    w_change_coin  = 3'b000;
    w_change_value = '0;
    if (r_remaining >= Q_VAL) begin
      w_change_coin  = 3'b100;
      w_change_value = Q_VAL;
    end else if (r_remaining >= D_VAL) begin
      w_change_coin  = 3'b010;
      w_change_value = D_VAL;
    end else if (r_remaining >= N_VAL) begin
      w_change_coin  = 3'b001;
      w_change_value = N_VAL;
    end
  end

  assign w_change_rem = r_remaining - w_change_value;

  always_comb begin
    w_state_nxt        = r_state;
    w_credit_nxt       = r_credit;
    w_remaining_nxt    = r_remaining;
    w_sel_idx_nxt      = r_sel_idx;
    w_coin_reject_nxt  = 1'b0;
    w_short_credit_nxt = 1'b0;
    case (r_state)
      ST_ACCEPT: begin
        if (enable) begin
          if (cancel) begin
            if (r_credit != '0) begin
              w_remaining_nxt = r_credit;
              w_credit_nxt    = '0;
              w_state_nxt     = ST_CHANGE;
            end
          end else if (w_coin_onehot) begin
            if (w_coin_sum <= MAX_SUM) w_credit_nxt = w_coin_sum[CREDIT_WIDTH-1:0];
            else                       w_coin_reject_nxt = 1'b1;
          end else if (w_sel_onehot) begin
            if (r_credit >= w_sel_price) begin
              w_sel_idx_nxt = w_sel_idx;
              w_state_nxt   = ST_VEND;
            end else begin
              w_short_credit_nxt = 1'b1;
            end
          end
        end
      end
      ST_VEND: begin
        w_credit_nxt = '0;
        if (w_vend_rem != '0) begin
          w_remaining_nxt = w_vend_rem;
          w_state_nxt     = ST_CHANGE;
        end else begin
          w_state_nxt = ST_ACCEPT;
        end
      end
      ST_CHANGE: begin
        if (enable && w_coin_onehot) w_coin_reject_nxt = 1'b1;
        // A residue smaller than the smallest coin cannot be paid out, so it is dropped.
        if (w_change_value == '0) begin
          w_remaining_nxt = '0;
          w_state_nxt     = ST_ACCEPT;
        end else if (change_ack) begin
          w_remaining_nxt = w_change_rem;
          if (w_change_rem == '0) w_state_nxt = ST_ACCEPT;
        end
      end
      default: begin
        w_state_nxt     = ST_ACCEPT;
        w_credit_nxt    = '0;
        w_remaining_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state        <= ST_ACCEPT;
      r_credit       <= '0;
      r_remaining    <= '0;
      r_sel_idx      <= '0;
      r_coin_reject  <= 1'b0;
      r_short_credit <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_remaining    <= w_remaining_nxt;
      r_sel_idx      <= w_sel_idx_nxt;
      r_coin_reject  <= w_coin_reject_nxt;
      r_short_credit <= w_short_credit_nxt;
    end
  end

  assign state        = r_state;
  assign credit       = (r_state == ST_CHANGE) ? r_remaining : r_credit;
  assign price        = w_sel_onehot ? w_sel_price : '0;
  assign vend         = (r_state == ST_VEND);
  assign vend_index   = r_sel_idx;
  assign coin_reject  = r_coin_reject;
  assign short_credit = r_short_credit;
  assign change_valid = (r_state == ST_CHANGE);
  assign change_coin  = change_valid ? w_change_coin : 3'b000;

endmodule

// File: tb/tb_vending_controller.sv
// tb/tb_vending_controller.sv - table-driven scoreboard bench for vending_controller
module tb_vending_controller;

  localparam logic [2:0] N = 3'b001;
  localparam logic [2:0] D = 3'b010;
  localparam logic [2:0] Q = 3'b100;

  logic       clock;
  logic       clear_n;
  logic       enable;
  logic [2:0] coin;
  logic [3:0] select;
  logic       cancel;
  logic       change_ack;
  logic [7:0] credit;
  logic [7:0] price;
  logic       vend;
  logic [1:0] vend_index;
  logic       coin_reject;
  logic       short_credit;
  logic       change_valid;
  logic [2:0] change_coin;
  logic [1:0] state;

  vending_controller dut (
    .clock(clock), .clear_n(clear_n), .enable(enable), .coin(coin), .select(select),
    .cancel(cancel), .change_ack(change_ack), .credit(credit), .price(price), .vend(vend),
    .vend_index(vend_index), .coin_reject(coin_reject), .short_credit(short_credit),
    .change_valid(change_valid), .change_coin(change_coin), .state(state)
  );

  typedef struct packed {
    logic [7:0] credit;
    logic [1:0] st;
    logic       vend;
    logic [1:0] vidx;
    logic       rej;
    logic       shrt;
    logic       cv;
    logic [2:0] cc;
    logic [7:0] price;
  } out_t;

  typedef struct {
    string      name;
    logic       en;
    logic [2:0] coin;
    logic [3:0] sel;
    logic       cancel;
    logic       ack;
    out_t       exp;
  } vec_t;

  typedef struct {
    string name;
    out_t  exp;
    bit    chk_idx;
  } sb_t;

  int   checks = 0;
  int   errors = 0;
  sb_t  sb_q[$];
  vec_t tbl[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  function automatic out_t eo(int cr, int st, bit vd, int vi, bit rj, bit sh, bit cv,
                              logic [2:0] cc, int pr);
    out_t o;
    o.credit = 8'(cr);
    o.st     = 2'(st);
    o.vend   = vd;
    o.vidx   = 2'(vi);
    o.rej    = rj;
    o.shrt   = sh;
    o.cv     = cv;
    o.cc     = cc;
    o.price  = 8'(pr);
    return o;
  endfunction

  function automatic vec_t mk(string n, bit en, logic [2:0] c, logic [3:0] s, bit ca, bit ak,
                              out_t e);
    vec_t v;
    v.name = n; v.en = en; v.coin = c; v.sel = s; v.cancel = ca; v.ack = ak; v.exp = e;
    return v;
  endfunction

  function automatic out_t sample();
    out_t a;
    a.credit = credit; a.st = state; a.vend = vend; a.vidx = vend_index; a.rej = coin_reject;
    a.shrt = short_credit; a.cv = change_valid; a.cc = change_coin; a.price = price;
    return a;
  endfunction

  task automatic push_exp(string n, out_t e, bit ci);
    sb_t s;
    s.name = n; s.exp = e; s.chk_idx = ci;
    sb_q.push_back(s);
  endtask

  task automatic check_pop();
    sb_t  s;
    out_t a;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue, expected a pending entry");
    end else begin
      s = sb_q.pop_front();
      a = sample();
      if (!s.chk_idx) begin
        a.vidx     = '0;
        s.exp.vidx = '0;
      end
      if (a !== s.exp) begin
        errors++;
        $display("FAIL %s: got credit=%0d state=%0d vend=%0b idx=%0d rej=%0b short=%0b cv=%0b cc=%b price=%0d; expected credit=%0d state=%0d vend=%0b idx=%0d rej=%0b short=%0b cv=%0b cc=%b price=%0d",
                 s.name, a.credit, a.st, a.vend, a.vidx, a.rej, a.shrt, a.cv, a.cc, a.price,
                 s.exp.credit, s.exp.st, s.exp.vend, s.exp.vidx, s.exp.rej, s.exp.shrt,
                 s.exp.cv, s.exp.cc, s.exp.price);
      end
    end
  endtask

  task automatic apply(vec_t v);
    @(negedge clock);
    enable = v.en; coin = v.coin; select = v.sel; cancel = v.cancel; change_ack = v.ack;
    push_exp(v.name, v.exp, v.exp.vend);
    @(posedge clock);
    #1;
    check_pop();
  endtask

  initial begin
    clear_n = 1'b0; enable = 1'b0; coin = 3'b000; select = 4'b0000;
    cancel = 1'b0; change_ack = 1'b0;

    //                 name              en coin    sel  can ack   credit st vd vi rj sh cv cc      price
    tbl.push_back(mk("no_enable",        0, Q,   4'b0000, 0, 0, eo( 0, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("quarter",          1, Q,   4'b0000, 0, 0, eo(25, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("dime_to_max",      1, D,   4'b0000, 0, 0, eo(35, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("nickel_over",      1, N,   4'b0000, 0, 0, eo(35, 0, 0, 0, 1, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("reject_clears",    0, 0,   4'b0000, 0, 0, eo(35, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("select_p0",        1, 0,   4'b0001, 0, 0, eo(35, 1, 1, 0, 0, 0, 0, 3'b000, 15)));
    tbl.push_back(mk("vend_to_change",   0, 0,   4'b0000, 0, 0, eo(20, 2, 0, 0, 0, 0, 1, D,       0)));
    tbl.push_back(mk("ack_first_dime",   0, 0,   4'b0000, 0, 1, eo(10, 2, 0, 0, 0, 0, 1, D,       0)));
    tbl.push_back(mk("ack_last_dime",    0, 0,   4'b0000, 0, 1, eo( 0, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("ack_in_accept",    0, 0,   4'b0000, 0, 1, eo( 0, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("coin_not_onehot",  1, 3'b011, 4'b0000, 0, 0, eo( 0, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("sel_not_onehot",   1, 0,   4'b0011, 0, 0, eo( 0, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("cancel_zero",      1, 0,   4'b0000, 1, 0, eo( 0, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("dime_a",           1, D,   4'b0000, 0, 0, eo(10, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("dime_b",           1, D,   4'b0000, 0, 0, eo(20, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("select_p3_short",  1, 0,   4'b1000, 0, 0, eo(20, 0, 0, 0, 0, 1, 0, 3'b000, 30)));
    tbl.push_back(mk("short_clears",     0, 0,   4'b0000, 0, 0, eo(20, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("select_p1_exact",  1, 0,   4'b0010, 0, 0, eo(20, 1, 1, 1, 0, 0, 0, 3'b000, 20)));
    tbl.push_back(mk("exact_no_change",  0, 0,   4'b0000, 0, 0, eo( 0, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("quarter_again",    1, Q,   4'b0000, 0, 0, eo(25, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("nickel_to_30",     1, N,   4'b0000, 0, 0, eo(30, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("cancel_beats_coin",1, N,   4'b0000, 1, 1, eo(30, 2, 0, 0, 0, 0, 1, Q,       0)));
    tbl.push_back(mk("refund_quarter",   0, 0,   4'b0000, 0, 1, eo( 5, 2, 0, 0, 0, 0, 1, N,       0)));
    tbl.push_back(mk("refund_nickel",    0, 0,   4'b0000, 0, 1, eo( 0, 0, 0, 0, 0, 0, 0, 3'b000,  0)));
    tbl.push_back(mk("refund_done",      0, 0,   4'b0000, 0, 0, eo( 0, 0, 0, 0, 0, 0, 0, 3'b000,  0)));

    repeat (2) @(posedge clock);
    #1;
    push_exp("reset_state", eo(0, 0, 0, 0, 0, 0, 0, 3'b000, 0), 1'b1);
    check_pop();
    @(negedge clock);
    clear_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Change held without ack: coin must stay stable; an enabled coin is refused.
    apply(mk("hold_quarter",  1, Q, 4'b0000, 0, 0, eo(25, 0, 0, 0, 0, 0, 0, 3'b000, 0)));
    apply(mk("hold_cancel",   1, 0, 4'b0000, 1, 0, eo(25, 2, 0, 0, 0, 0, 1, Q,      0)));
    for (int k = 0; k < 10; k++) begin
      apply(mk($sformatf("hold_noack_%0d", k), (k == 4), (k == 4) ? D : 3'b000, 4'b0000, 0, 0,
               eo(25, 2, 0, 0, (k == 4), 0, 1, Q, 0)));
    end

    // Asynchronous reset between edges abandons the pending change.
    #2;
    clear_n = 1'b0;
    #1;
    push_exp("async_reset", eo(0, 0, 0, 0, 0, 0, 0, 3'b000, 0), 1'b1);
    check_pop();
    @(negedge clock);
    clear_n = 1'b1;
    apply(mk("after_reset_idle", 0, 0, 4'b0000, 0, 0, eo(0, 0, 0, 0, 0, 0, 0, 3'b000, 0)));
    apply(mk("after_reset_coin", 1, N, 4'b0000, 0, 0, eo(5, 0, 0, 0, 0, 0, 0, 3'b000, 0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
